// File: rtl/cpu_run_controller.sv
// Run sequencer for the 5-stage CPU: holds it in reset, runs it until the halt word or a
// timeout, drains the pipeline, then streams data memory out over a valid/ready port.
module cpu_run_controller #(
   parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned MEM_DEPTH    = 512,
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned MAX_CYCLES   = 100000
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              start,
   input  logic [31:0]       inst_f,
   input  logic              stall_in,
   output logic              cpu_rst,
   output logic              cpu_en,
   output logic              fetch_kill,
   output logic [ADDR_W-1:0] dump_addr,
   input  logic [31:0]       dump_rd_data,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_RUN,
      S_DRAIN,
      S_DFETCH,
      S_DSEND,
      S_DONE
   } state_t;

   localparam int unsigned       DRN_W      = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(DRAIN_CYCLES);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

   state_t            state_q, state_d;
   logic [DRN_W-1:0]  drain_q, drain_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [31:0]       data_q,  data_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              tmo_q,   tmo_d;
   logic              halt_hit;

   // A halt word held in IF by a hazard stall is not yet a committed fetch.
   assign halt_hit = (inst_f == HALT_WORD) && !stall_in;

   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      addr_d     = addr_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      cpu_rst    = 1'b0;
      cpu_en     = 1'b0;
      fetch_kill = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            cpu_rst = 1'b1;
            busy    = 1'b0;
            if (start) state_d = S_CRST;
         end
         S_CRST: begin
            cpu_rst = 1'b1;
            cnt_d   = '0;
            tmo_d   = 1'b0;
            addr_d  = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cpu_en = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            // Halt wins over timeout so a run finishing on its last allowed cycle is clean.
            if (halt_hit) begin
               fetch_kill = 1'b1;
               drain_d    = DRAIN_LOAD;
               state_d    = S_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               tmo_d   = 1'b1;
               drain_d = DRAIN_LOAD;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            cpu_en     = 1'b1;
            fetch_kill = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            if (!stall_in) begin
               drain_d = drain_q - DRN_W'(1);
               if (drain_q == DRN_W'(1)) state_d = S_DFETCH;
            end
         end
         S_DFETCH: begin
            data_d  = dump_rd_data;
            state_d = S_DSEND;
         end
         S_DSEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (addr_q == ADDR_LAST) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_DFETCH;
               end
            end
         end
         S_DONE: begin
            done = 1'b1;
            busy = 1'b0;
            if (start) state_d = S_CRST;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         drain_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign dump_addr   = addr_q;
   assign out_data    = data_q;
   assign cycle_count = cnt_q;
   assign timeout     = tmo_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a table of run scenarios, hand-built corner sequences and
// randomized runs checked against a cycle-count model and an address-ordered dump scoreboard.
module tb_cpu_run_controller;

   localparam int          MAXC  = 20;
   localparam int          DEPTH = 512;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic [31:0] inst_f = 32'h0;
   logic        stall_in = 1'b0;
   logic        cpu_rst, cpu_en, fetch_kill;
   logic [8:0]  dump_addr;
   logic [31:0] dump_rd_data, out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy, done, timeout;
   logic [31:0] cycle_count;

   logic [31:0] mem [DEPTH];
   assign dump_rd_data = mem[dump_addr];

   int n_chk  = 0;
   int n_fail = 0;

   cpu_run_controller #(
      .HALT_WORD(HALT), .DRAIN_CYCLES(4), .MEM_DEPTH(DEPTH), .ADDR_W(9),
      .CNT_W(32), .MAX_CYCLES(MAXC)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .start(start), .inst_f(inst_f), .stall_in(stall_in),
      .cpu_rst(cpu_rst), .cpu_en(cpu_en), .fetch_kill(fetch_kill), .dump_addr(dump_addr),
      .dump_rd_data(dump_rd_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .timeout(timeout),
      .cycle_count(cycle_count)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int          halt_cyc;
      logic [63:0] stalls;
      int          run;
      int          drain;
      int          cnt;
      bit          tmo;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Run length, drain length and cycle count derived from the run rules cycle by cycle.
   function automatic void model(input int halt_cyc, input logic [63:0] stalls,
                                 output int run, output int drain, output int cnt,
                                 output bit tmo);
      int need;
      int t;
      run = 0;
      tmo = 1'b0;
      for (int c = 1; c <= MAXC; c++) begin
         if (halt_cyc != 0 && c >= halt_cyc && !stalls[c-1]) begin
            run = c;
            break;
         end
      end
      if (run == 0) begin
         run = MAXC;
         tmo = 1'b1;
      end
      need  = 4;
      drain = 0;
      t     = run;
      while (need > 0) begin
         t++;
         drain++;
         if (!(t <= 64 && stalls[t-1])) need--;
      end
      cnt = run + drain;
   endfunction

   task automatic run_scenario(input int halt_cyc, input logic [63:0] stalls, input int rmode,
                               input bit noise, input int exp_run, input int exp_drain,
                               input int exp_cnt, input bit exp_tmo, input int abort_at,
                               input string tag);
      int          t, first_kill, k, cyc;
      bit          hold, ended;
      logic [31:0] hd;
      logic [8:0]  ha;

      @(negedge CLOCK); start = 1'b1; #1;
      @(negedge CLOCK); start = 1'b0; #1;
      chk({tag, "/crst"}, {cpu_rst, cpu_en, busy, done}, 4'b1010);

      t = 0; first_kill = 0; ended = 1'b0;
      while (!ended) begin
         t++;
         @(negedge CLOCK);
         inst_f   = (halt_cyc != 0 && t >= halt_cyc) ? HALT : ($urandom & 32'h7FFF_FFFF);
         stall_in = (t <= 64) ? stalls[t-1] : 1'b0;
         start    = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
         #1;
         if (!cpu_en) begin
            ended = 1'b1;
         end else begin
            if (fetch_kill && first_kill == 0) first_kill = t;
            chk({tag, "/run_cpu_rst"}, {cpu_rst, busy}, 2'b01);
            if (t >= 200) begin
               chk({tag, "/run_bound"}, 0, 1);
               ended = 1'b1;
            end
         end
      end
      stall_in = 1'b0;
      chk({tag, "/en_cycles"}, t - 1, exp_run + exp_drain);
      chk({tag, "/halt_kill"}, first_kill, exp_tmo ? exp_run + 1 : exp_run);
      chk({tag, "/cnt_drained"}, cycle_count, exp_cnt);
      chk({tag, "/tmo_drained"}, timeout, exp_tmo);
      chk({tag, "/dfetch_outs"}, {out_valid, cpu_rst, fetch_kill, busy}, 4'b0001);

      k = 0; cyc = 0; hold = 1'b0; ended = 1'b0;
      while (!ended) begin
         cyc++;
         @(negedge CLOCK);
         out_ready = (rmode == 0) ? 1'b1 :
                     (rmode == 1) ? ($urandom_range(0, 1) == 1) : ((cyc % 3) == 0);
         start     = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
         #1;
         if (cyc == 1) chk({tag, "/first_valid"}, out_valid, 1);
         if (hold) chk({tag, "/held"}, {out_valid, out_data, dump_addr}, {1'b1, hd, ha});
         hold = 1'b0;
         if (abort_at >= 0 && out_valid && dump_addr == 9'(abort_at)) begin
            start = 1'b0;
            RESET = 1'b1;
            #1;
            chk({tag, "/async_rst"}, {out_valid, cpu_rst, cpu_en, busy, done, dump_addr},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0});
            @(negedge CLOCK);
            RESET = 1'b0;
            out_ready = 1'b0;
            return;
         end
         if (out_valid && out_ready) begin
            chk({tag, "/word"}, out_data, 32'(k * 3));
            chk({tag, "/addr"}, dump_addr, k);
            k++;
            if (k == DEPTH) ended = 1'b1;
         end else if (out_valid) begin
            hold = 1'b1;
            hd   = out_data;
            ha   = dump_addr;
         end
         if (cyc >= 6000) begin
            chk({tag, "/dump_bound"}, 0, 1);
            ended = 1'b1;
         end
      end
      if (rmode == 0) chk({tag, "/throughput"}, cyc, 2 * DEPTH - 1);
      @(negedge CLOCK);
      start = 1'b0; out_ready = 1'b0;
      #1;
      chk({tag, "/done"}, {done, busy, out_valid, cpu_en, cpu_rst}, 5'b10000);
      chk({tag, "/cnt_done"}, cycle_count, exp_cnt);
      chk({tag, "/tmo_done"}, timeout, exp_tmo);
      chk({tag, "/addr_done"}, dump_addr, DEPTH - 1);
   endtask

   initial begin
      int          r_run, r_drain, r_cnt, r_halt;
      bit          r_tmo;
      logic [63:0] r_st;

      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 3);
      tbl[0] = '{10, 64'h0, 10, 4, 14, 1'b0};
      tbl[1] = '{10, (64'h1 << 9) | (64'h1 << 12), 11, 5, 16, 1'b0};
      tbl[2] = '{0, 64'h0, 20, 4, 24, 1'b1};
      tbl[3] = '{20, 64'h0, 20, 4, 24, 1'b0};
      tbl[4] = '{1, 64'h0, 1, 4, 5, 1'b0};
      tbl[5] = '{5, (64'h1 << 5) | (64'h1 << 6), 5, 6, 11, 1'b0};
      tbl[6] = '{3, (64'h1 << 2) | (64'h1 << 3), 5, 4, 9, 1'b0};
      tbl[7] = '{0, (64'h1 << 19) | (64'h1 << 21), 20, 5, 25, 1'b1};

      repeat (3) @(negedge CLOCK);
      #1;
      chk("rst_ctrl", {cpu_rst, cpu_en, fetch_kill, out_valid, busy, done, timeout}, 7'b1000000);
      chk("rst_addr", dump_addr, 0);
      chk("rst_cnt", cycle_count, 0);
      chk("rst_data", out_data, 0);
      @(negedge CLOCK); RESET = 1'b0;
      @(negedge CLOCK); #1;
      chk("idle", {cpu_rst, cpu_en, busy, done}, 4'b1000);

      for (int i = 0; i < 8; i++)
         run_scenario(tbl[i].halt_cyc, tbl[i].stalls, 0, 1'b0, tbl[i].run, tbl[i].drain,
                      tbl[i].cnt, tbl[i].tmo, -1, $sformatf("vec%0d", i));

      run_scenario(4, 64'h0, 2, 1'b1, 4, 4, 8, 1'b0, -1, "rdy001");

      run_scenario(2, 64'h0, 0, 1'b0, 2, 4, 6, 1'b0, 37, "abort");
      @(negedge CLOCK); #1;
      chk("abort_idle", {cpu_rst, busy, done, out_valid}, 4'b1000);
      run_scenario(3, 64'h0, 0, 1'b0, 3, 4, 7, 1'b0, -1, "rerun");

      for (int r = 0; r < 6; r++) begin
         r_halt = $urandom_range(0, 24);
         r_st   = 64'h0;
         for (int i = 0; i < 40; i++) r_st[i] = ($urandom_range(0, 3) == 0);
         model(r_halt, r_st, r_run, r_drain, r_cnt, r_tmo);
         run_scenario(r_halt, r_st, 1, 1'b1, r_run, r_drain, r_cnt, r_tmo, -1,
                      $sformatf("rnd%0d_h%0d", r, r_halt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
